// File: rtl/bus_mailbox_pkg.sv
// Shared definitions for the bus mailbox: register map, STATUS/CONTROL bit
// positions, FSM encoding and the value returned by a read of an empty FIFO.
package bus_mailbox_pkg;

  localparam int          ADDR_SEL_BIT  = 2;
  localparam logic [31:0] DATA_OFFSET   = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFFSET = 32'h0000_0004;

  localparam int STAT_EMPTY     = 16;
  localparam int STAT_FULL      = 17;
  localparam int STAT_OVERFLOW  = 18;
  localparam int STAT_UNDERFLOW = 19;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLEAR = 1;

  localparam logic [31:0] EMPTY_READ = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    ACK
  } state_e;

endpackage

// File: rtl/bus_mailbox_if.sv
// Internal-bus responder interface: request/ack handshake plus address and data.
interface bus_mailbox_if;

  logic        i_select;
  logic        i_read_rq;
  logic        i_write_rq;
  logic [31:0] i_address;
  logic [31:0] i_data;
  logic        o_ack;
  logic [31:0] o_data;

  modport master (
    output i_select, i_read_rq, i_write_rq, i_address, i_data,
    input  o_ack, o_data
  );

  modport slave (
    input  i_select, i_read_rq, i_write_rq, i_address, i_data,
    output o_ack, o_data
  );

endinterface

// File: rtl/bus_mailbox_ram.sv
// Simple dual-port RAM with one write port and a registered read port,
// written so synthesis maps it onto block RAM.
module bus_mailbox_ram #(
  parameter int ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  // NOTE: the array has no reset; resetting it would prevent block-RAM inference,
  // and the FIFO pointers already guarantee stale words are never returned.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_mailbox.sv
// Word FIFO mailbox on the internal bus: DATA register pushes/pops the FIFO,
// STATUS register reports fill level and sticky error flags, writes act as CONTROL.
module bus_mailbox
  import bus_mailbox_pkg::*;
#(
  parameter int DEPTH_BITS = 9
) (
  input  logic          i_clk,
  input  logic          i_reset,
  bus_mailbox_if.slave  bus,
  output logic          o_not_empty
);

  localparam logic [DEPTH_BITS:0] FULL_COUNT = {1'b1, {DEPTH_BITS{1'b0}}};

  state_e                state, state_next;
  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  overflow, underflow, rd_was_empty;
  logic                  empty, full;
  logic                  accept, is_status, do_write, do_read;
  logic                  ram_we, ram_re;
  logic [31:0]           ram_q, status;
  logic                  unused_addr;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign is_status = (bus.i_address[ADDR_SEL_BIT] == STATUS_OFFSET[ADDR_SEL_BIT]);
  assign accept    = !i_reset && (state == IDLE) && bus.i_select
                     && (bus.i_read_rq || bus.i_write_rq);
  // A simultaneous read is dropped in favour of the write.
  assign do_write  = accept && bus.i_write_rq;
  assign do_read   = accept && !bus.i_write_rq;

  assign ram_we = do_write && !is_status && !full;
  assign ram_re = do_read && !is_status;

  // Gated so a reset landing in the ACK cycle suppresses the pulse.
  assign bus.o_ack = (state == ACK) && !i_reset;

  assign unused_addr = ^{bus.i_address[31:ADDR_SEL_BIT+1], bus.i_address[ADDR_SEL_BIT-1:0]};

  bus_mailbox_ram #(.ADDR_BITS(DEPTH_BITS)) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (bus.i_data),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    status                 = '0;
    status[15:0]           = 16'(count);
    status[STAT_EMPTY]     = empty;
    status[STAT_FULL]      = full;
    status[STAT_OVERFLOW]  = overflow;
    status[STAT_UNDERFLOW] = underflow;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (do_read && !is_status) ? RD_WAIT : ACK;
      RD_WAIT: state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_was_empty <= 1'b0;
      o_not_empty  <= 1'b0;
      bus.o_data   <= EMPTY_READ;
    end else begin
      o_not_empty <= (count != '0);

      if (state == RD_WAIT) bus.o_data <= rd_was_empty ? EMPTY_READ : ram_q;

      if (do_write) begin
        if (is_status) begin
          if (bus.i_data[CTRL_FLUSH]) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
          end
          if (bus.i_data[CTRL_CLEAR]) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end
        end else if (full) begin
          overflow <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count + 1'b1;
        end
      end

      if (do_read) begin
        if (is_status) begin
          bus.o_data <= status;
        end else if (empty) begin
          underflow    <= 1'b1;
          rd_was_empty <= 1'b1;
        end else begin
          rd_was_empty <= 1'b0;
          rd_ptr       <= rd_ptr + 1'b1;
          count        <= count - 1'b1;
        end
      end
    end
  end

endmodule
